ram_bcd_loader: RTL

//  Sequential writer for the memoram display path: the operator keys two BCD digits (tens, units)
//  and pulses store. The block converts them to binary (tens*10+units) and writes the value into
//  the RAM write port at an auto-incrementing address, with full/error reporting.
//  It is the input-side counterpart of the binary->decimal 7-seg read path.

---
 rtl/ram_loader_pkg.sv | 29 ++
 rtl/ram_bcd_loader_sync.sv | 28 ++
 rtl/ram_bcd_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the BCD-to-RAM loader.
// State encoding, digit limit and BCD-to-binary conversion.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WRITE,
    VRD,
    VWAIT,
    VCMP,
    FULL
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // tens*10 + units, written as shifts to keep it multiplier-free
  function automatic logic [6:0] bcd2bin(
    input logic [3:0] tens,
    input logic [3:0] units
  );
    logic [6:0] tw;
    logic [6:0] uw;
    tw = {3'b000, tens};
    uw = {3'b000, units};
    return (tw << 3) + (tw << 1) + uw;
  endfunction

endpackage

// File: rtl/ram_bcd_loader_sync.sv
// Key synchronizer: two-flop metastability filter plus
// a rising-edge detector giving one pulse per press.
module key_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/ram_bcd_loader.sv
// Keyed two-digit BCD value writer with auto-incrementing RAM address.
// Define RAM_VERIFY_EN to add a readback compare after every write.
import ram_loader_pkg::*;

module ram_bcd_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int WRAP   = 0,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [3:0]        tens,
  input  logic [3:0]        units,
  input  logic              store,
  input  logic              clear,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err_bcd,
  output logic              verify_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CMAX = (ADDR_W + 1)'(DEPTH);

  state_e            st;
  logic              start;
  logic [3:0]        t_q;
  logic [3:0]        u_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rda;
  logic [ADDR_W:0]   count_nx;
  logic              bad;
  logic              full_nx;

  key_edge_sync u_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (store),
    .pulse  (start)
  );

  assign bad      = (tens > BCD_MAX) || (units > BCD_MAX);
  assign count_nx = (count == CMAX) ? count : count + 1'b1;
  assign full_nx  = (WRAP == 0) && (count_nx == CMAX);

`ifdef RAM_VERIFY_EN
  logic       verr;
  logic [7:0] wcnt;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st      <= IDLE;
      addr    <= '0;
      count   <= '0;
      data    <= '0;
      rda     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      err_bcd <= 1'b0;
`ifdef RAM_VERIFY_EN
      verr    <= 1'b0;
      wcnt    <= '0;
`endif
    end else if (clear) begin
      st      <= IDLE;
      addr    <= '0;
      count   <= '0;
      err_bcd <= 1'b0;
`ifdef RAM_VERIFY_EN
      verr    <= 1'b0;
`endif
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            if (bad) begin
              err_bcd <= 1'b1;
            end else begin
              err_bcd <= 1'b0;
              t_q     <= tens;
              u_q     <= units;
              st      <= CONV;
            end
          end
        end
        CONV: begin
          data <= DATA_W'(bcd2bin(t_q, u_q));
          st   <= WRITE;
        end
        WRITE: begin
          addr  <= addr + 1'b1;
          count <= count_nx;
          rda   <= addr;
`ifdef RAM_VERIFY_EN
          st    <= VRD;
`else
          st    <= full_nx ? FULL : IDLE;
`endif
        end
`ifdef RAM_VERIFY_EN
        VRD: begin
          wcnt <= 8'd1;
          st   <= (RD_LAT == 0) ? VCMP : VWAIT;
        end
        VWAIT: begin
          if (wcnt >= 8'(RD_LAT)) st <= VCMP;
          else wcnt <= wcnt + 8'd1;
        end
        VCMP: begin
          if (q != data) verr <= 1'b1;
          st <= ((WRAP == 0) && (count == CMAX)) ? FULL : IDLE;
        end
`endif
        FULL:    st <= FULL;
        default: st <= IDLE;
      endcase
    end
  end

  assign wren      = (st == WRITE);
  assign wraddress = addr;
  assign rdaddress = rda;
  assign busy      = (st != IDLE) && (st != FULL);
  assign full      = (st == FULL);

`ifdef RAM_VERIFY_EN
  assign verify_err = verr;
`else
  logic unused_q;
  assign unused_q   = ^{q, 32'(RD_LAT), full_nx & 1'b0};
  assign verify_err = 1'b0;
`endif

endmodule
